// File: rtl/cuenta_ceros_pkg.sv
// cuenta_ceros_pkg: shared FSM encoding and default widths for the zero-counter arbiter and its counter unit
package cuenta_ceros_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;
  localparam int CC_DATA_W = 8;
  localparam int CC_CNT_W  = 3;
endpackage

// File: rtl/arbitro_cuenta_ceros_rr.sv
// arbitro_rr: combinational rotating-priority select, index rr_ptr has highest priority
module arbitro_rr #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             any,
  output logic [ID_W-1:0]  idx
);
  int j;
  always_comb begin
    any = |req;
    idx = '0;
    j   = 0;
    // scan from the lowest priority up so the highest-priority hit is written last
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % N_REQ;
      if (req[j]) idx = ID_W'(j);
    end
  end
endmodule

// File: rtl/arbitro_cuenta_ceros.sv
// arbitro_cuenta_ceros: round-robin sharing of one zero-counter unit with start/run sequencing and a watchdog
module arbitro_cuenta_ceros
  import cuenta_ceros_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = CC_DATA_W,
  parameter int CNT_W   = CC_CNT_W,
  parameter int TIMEOUT = 31,
  parameter int TO_W    = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [CNT_W-1:0]        res_count,
  output logic                    res_err,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id,
  output logic [DATA_W-1:0]       cc_a,
  output logic                    cc_start,
  input  logic [CNT_W-1:0]        cc_count,
  input  logic                    cc_done
);
  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [CNT_W-1:0]  res_count_q, res_count_d;
  logic              res_err_q, res_err_d;
  logic [DATA_W-1:0] cc_a_q, cc_a_d;
  logic              cc_start_q, cc_start_d;
  logic [TO_W-1:0]   timer_q, timer_d, timer_inc;
  logic              any;
  logic [ID_W-1:0]   idx;

  arbitro_rr #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .any    (any),
    .idx    (idx)
  );

  assign timer_inc = timer_q + TO_W'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    ack_d       = '0;
    res_count_d = res_count_q;
    res_err_d   = res_err_q;
    cc_a_d      = cc_a_q;
    cc_start_d  = 1'b0;
    timer_d     = timer_q;
    case (state_q)
      IDLE: if (any) begin
        grant_id_d = idx;
        cc_a_d     = req_data[idx*DATA_W +: DATA_W];
        cc_start_d = 1'b1;
        state_d    = LOAD;
      end
      LOAD: begin
        timer_d = '0;
        state_d = RUN;
      end
      RUN: begin
        timer_d = timer_inc;
        // done is checked first so a completion on the last watchdog cycle still wins
        if (cc_done || timer_inc == TO_W'(TIMEOUT)) begin
          res_count_d = cc_done ? cc_count : '0;
          res_err_d   = !cc_done;
          ack_d       = N_REQ'(1) << grant_id_q;
          state_d     = RESP;
        end
      end
      RESP: begin
        rr_ptr_d = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      ack_q       <= '0;
      res_count_q <= '0;
      res_err_q   <= 1'b0;
      cc_a_q      <= '0;
      cc_start_q  <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      ack_q       <= ack_d;
      res_count_q <= res_count_d;
      res_err_q   <= res_err_d;
      cc_a_q      <= cc_a_d;
      cc_start_q  <= cc_start_d;
      timer_q     <= timer_d;
    end
  end

  assign ack       = ack_q;
  assign res_count = res_count_q;
  assign res_err   = res_err_q;
  assign busy      = state_q != IDLE;
  assign grant_id  = grant_id_q;
  assign cc_a      = cc_a_q;
  assign cc_start  = cc_start_q;
endmodule

// File: tb/tb_arbitro_cuenta_ceros.sv
// tb_arbitro_cuenta_ceros: randomized bench with a programmable counter responder and a round-robin reference model
module tb_arbitro_cuenta_ceros;
  localparam int N = 4;
  localparam int TMO = 31;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic [2:0]  res_count;
  logic        res_err;
  logic        busy;
  logic [1:0]  grant_id;
  logic [7:0]  cc_a;
  logic        cc_start;
  logic [2:0]  cc_count = '0;
  logic        cc_done = 1'b0;

  int checks = 0;
  int errors = 0;
  int rr_exp = 0;
  int delay = 1;
  logic [2:0] rsp_cnt = '0;

  arbitro_cuenta_ceros dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .res_count(res_count), .res_err(res_err), .busy(busy),
    .grant_id(grant_id), .cc_a(cc_a), .cc_start(cc_start),
    .cc_count(cc_count), .cc_done(cc_done)
  );

  always #5 clk = ~clk;

  // responder: raises done during RUN cycle number `delay` (counted from the cycle after cc_start)
  initial begin
    int run_cyc;
    bit armed;
    run_cyc = 0;
    armed = 0;
    forever begin
      @(negedge clk);
      if (cc_start) begin
        armed = 1; run_cyc = 0; cc_done = 1'b0;
      end else if (armed && busy) begin
        run_cyc++;
        cc_done = (run_cyc == delay);
        cc_count = cc_done ? rsp_cnt : 3'(run_cyc);
      end else begin
        armed = 0; cc_done = 1'b0;
      end
    end
  end

  function automatic int pick(input logic [3:0] r, input int ptr);
    for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // runs one operation from IDLE; lat is the cycle number (1 = IDLE sample) in which ack appeared
  task automatic run_txn(output logic [3:0] ackv, output int lat, output int starts,
                         output logic [7:0] a_seen, output logic busy_after);
    int cyc;
    cyc = 0; starts = 0; ackv = '0; a_seen = '0;
    while (ackv == 0 && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cc_start) begin starts++; a_seen = cc_a; end
      ackv = ack;
    end
    lat = cyc + 1;
    if (ackv == 0) begin
      errors++;
      $display("FAIL ack_wait: no ack after %0d cycles", cyc);
    end
    @(posedge clk);
    @(negedge clk);
    busy_after = busy;
  endtask

  // full check of one operation against the model
  task automatic expect_txn(input string tag, input logic [3:0] ackv, input int lat, input int starts,
                            input logic [7:0] a_seen, input logic busy_after, input logic [3:0] r);
    int g;
    bit ok_done;
    int exp_lat;
    logic [2:0] exp_cnt;
    g = pick(r, rr_exp);
    ok_done = delay >= 1 && delay <= TMO;
    exp_lat = 3 + (ok_done ? delay : TMO);
    exp_cnt = ok_done ? rsp_cnt : 3'd0;
    checks++;
    if (ackv !== 4'(1 << g) || lat != exp_lat || res_count !== exp_cnt || res_err !== !ok_done ||
        starts != 1 || a_seen !== req_data[g*8 +: 8] || busy_after !== 1'b0 || grant_id !== 2'(g)) begin
      errors++;
      $display("FAIL %s: ack=%b lat=%0d cnt=%0d err=%b starts=%0d a=%h busy=%b gid=%0d required ack=%b lat=%0d cnt=%0d err=%b starts=1 a=%h busy=0 gid=%0d",
               tag, ackv, lat, res_count, res_err, starts, a_seen, busy_after, grant_id,
               4'(1 << g), exp_lat, exp_cnt, !ok_done, req_data[g*8 +: 8], g);
    end
    rr_exp = (g + 1) % N;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({ack, res_count, res_err, busy, grant_id, cc_a, cc_start} !== '0) begin
      errors++;
      $display("FAIL reset: outputs=%h required 0", {ack, res_count, res_err, busy, grant_id, cc_a, cc_start});
    end
    @(negedge clk);
    rst_n = 1'b1;
    rr_exp = 0;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [3:0] av; int lat, st; logic [7:0] a; logic b;
    req_data = {24'($urandom), 8'h0C};
    req = 4'b0001; delay = 5; rsp_cnt = 3'd2;
    run_txn(av, lat, st, a, b);
    req = '0;
    expect_txn("single", av, lat, st, a, b, 4'b0001);
  endtask

  task automatic test_back_to_back;
    logic [3:0] av; int lat, st; logic [7:0] a; logic b;
    int hist[$];
    req = 4'b1111; delay = 1;
    for (int i = 0; i < 6; i++) begin
      req_data = $urandom;
      rsp_cnt = 3'($urandom);
      run_txn(av, lat, st, a, b);
      expect_txn("rotate", av, lat, st, a, b, 4'b1111);
      hist.push_back($clog2(av));
      if (hist.size() >= 4) begin
        checks++;
        if (hist[$] == hist[$-1] || hist[$] == hist[$-2] || hist[$] == hist[$-3]) begin
          errors++;
          $display("FAIL fairness: grant %0d repeated within 4 acks", hist[$]);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_wrap;
    logic [3:0] av; int lat, st; logic [7:0] a; logic b;
    delay = 2; rsp_cnt = 3'd5; req_data = $urandom;
    req = 4'b0100;
    run_txn(av, lat, st, a, b);
    expect_txn("wrap_setup", av, lat, st, a, b, 4'b0100);
    req = 4'b0101;
    run_txn(av, lat, st, a, b);
    expect_txn("wrap_first", av, lat, st, a, b, 4'b0101);
    req = 4'b0100;
    run_txn(av, lat, st, a, b);
    expect_txn("wrap_second", av, lat, st, a, b, 4'b0100);
    req = '0;
  endtask

  task automatic test_timeout;
    logic [3:0] av; int lat, st; logic [7:0] a; logic b;
    logic [3:0] r;
    req_data = $urandom;
    r = 4'(1 << $urandom_range(3, 0));
    req = r; delay = 1000; rsp_cnt = 3'd6;
    run_txn(av, lat, st, a, b);
    expect_txn("timeout", av, lat, st, a, b, r);
    req = 4'b1000; delay = TMO; rsp_cnt = 3'd7;
    run_txn(av, lat, st, a, b);
    expect_txn("done_at_limit", av, lat, st, a, b, 4'b1000);
    req = 4'b0010; delay = 3; rsp_cnt = 3'd1;
    run_txn(av, lat, st, a, b);
    expect_txn("after_timeout", av, lat, st, a, b, 4'b0010);
    req = '0;
  endtask

  task automatic test_random;
    logic [3:0] av; int lat, st; logic [7:0] a; logic b;
    logic [3:0] r;
    r = 4'($urandom_range(15, 1));
    for (int i = 0; i < 20; i++) begin
      req = r;
      req_data = $urandom;
      delay = ($urandom_range(9, 0) == 0) ? $urandom_range(40, 30) : $urandom_range(8, 1);
      rsp_cnt = 3'($urandom);
      run_txn(av, lat, st, a, b);
      expect_txn("random", av, lat, st, a, b, r);
      r = (r & ~av) | 4'($urandom);
      if (r == 0) r = 4'($urandom_range(15, 1));
    end
    req = '0;
  endtask

  task automatic test_reset_mid;
    logic [3:0] av; int lat, st; logic [7:0] a; logic b;
    bit seen_ack;
    req_data = $urandom;
    req = 4'b0010; delay = 10; rsp_cnt = 3'd4;
    seen_ack = 0;
    repeat (4) begin
      @(posedge clk);
      #1 if (ack != 0) seen_ack = 1;
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (seen_ack || {ack, res_count, res_err, busy, grant_id, cc_a, cc_start} !== '0) begin
      errors++;
      $display("FAIL reset_mid: early_ack=%b outputs=%h required no ack and 0", seen_ack,
               {ack, res_count, res_err, busy, grant_id, cc_a, cc_start});
    end
    @(negedge clk);
    rst_n = 1'b1;
    rr_exp = 0;
    delay = 3; rsp_cnt = 3'($urandom);
    run_txn(av, lat, st, a, b);
    expect_txn("after_reset", av, lat, st, a, b, 4'b0010);
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
